// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one combinational signed array multiplier between two requesters.
// Operands are held for SETTLE_CYCLES clocks so the carry chain gets a multicycle path.

module array_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product
);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] row;

    // Sign-extended partial-product rows; the top row of b carries negative weight.
    always_comb begin
        acc = '0;
        row = '0;
        for (int i = 0; i < WIDTH; i++) begin
            row = b[i] ? ({{WIDTH{a[WIDTH-1]}}, a} << i) : '0;
            if (i == WIDTH - 1) begin
                acc = acc - row;
            end else begin
                acc = acc + row;
            end
        end
        product = acc;
    end

endmodule

module mult_share_arbiter #(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [WIDTH-1:0]    req0_a,
    input  logic [WIDTH-1:0]    req0_b,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [WIDTH-1:0]    req1_a,
    input  logic [WIDTH-1:0]    req1_b,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic                resp_id,
    output logic [2*WIDTH-1:0]  resp_product,
    output logic                busy,
    output logic [15:0]         op_count
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [3:0]         cnt;
    logic               last_grant;
    logic               pend_id;
    logic               grant;
    logic               accept;
    logic [2*WIDTH-1:0] mult_out;

    array_multiplier #(
        .WIDTH(WIDTH)
    ) u_mult (
        .a       (op_a),
        .b       (op_b),
        .product (mult_out)
    );

    // With both requesters waiting, the one that did not win last time goes next.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
        req0_ready = (state == IDLE) && !grant;
        req1_ready = (state == IDLE) && grant;
        accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
        busy       = (state != IDLE);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = CALC;
            CALC:    if (cnt == 4'd0) state_next = DONE;
            DONE:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            resp_valid   <= 1'b0;
            resp_id      <= 1'b0;
            resp_product <= '0;
            op_a         <= '0;
            op_b         <= '0;
            cnt          <= 4'd0;
            last_grant   <= 1'b1;
            pend_id      <= 1'b0;
            op_count     <= 16'd0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_a       <= grant ? req1_a : req0_a;
                        op_b       <= grant ? req1_b : req0_b;
                        last_grant <= grant;
                        pend_id    <= grant;
                        cnt        <= CNT_INIT;
                    end
                end
                CALC: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        resp_product <= mult_out;
                        resp_id      <= pend_id;
                        resp_valid   <= 1'b1;
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        op_count   <= op_count + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Time-shares one combinational array_multiplier (32x32 signed -> 64-bit) between two requesters.
- Round-robin arbitration; valid/ready handshake on each request port and on the single response port.
- Registers the operands and holds them for SETTLE_CYCLES clocks, so the long array carry path gets a multicycle budget.
- Returns the product tagged with the requester id, and keeps a wrap-around completed-operation counter.

Parameters:
- WIDTH, 32, operand width; only 32 is supported (matches array_multiplier); product is 2*WIDTH.
- SETTLE_CYCLES, 2, clocks operands are held at the multiplier before capture; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 accepted this cycle
- req0_a  in  WIDTH  requester 0 multiplicand, signed
- req0_b  in  WIDTH  requester 0 multiplier, signed
- req1_valid  in  1  requester 1 has an operation
- req1_ready  out  1  requester 1 accepted this cycle
- req1_a  in  WIDTH  requester 1 multiplicand, signed
- req1_b  in  WIDTH  requester 1 multiplier, signed
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes result
- resp_id  out  1  requester that issued the result
- resp_product  out  2*WIDTH  signed product
- busy  out  1  state != IDLE
- op_count  out  16  completed responses, wraps 0xFFFF -> 0

Behaviour:
- Clocking/reset: clk is the only clock; rst is synchronous, active-high.
- Reset values: state IDLE, resp_valid 0, resp_id 0, resp_product 0, op_a/op_b 0, cnt 0, last_grant 1 (requester 0 wins first), op_count 0, busy 0.
- Reset mid-operation abandons the in-flight op; no response is produced.
- FSM states: IDLE, CALC, DONE.
- IDLE, grant logic:
  - Grant is combinational from the valids.
  - One valid only: grant that requester.
  - Both valid: grant the requester != last_grant.
  - reqN_ready = IDLE && grant==N; ready is never high in CALC or DONE.
- IDLE, accept (valid && ready):
  - Latch a/b into op_a/op_b; latch grant into last_grant and the pending id.
  - cnt <= SETTLE_CYCLES-1; state -> CALC.
- CALC:
  - op_a/op_b stable and driving array_multiplier.
  - cnt != 0: decrement.
  - cnt == 0: resp_product <= multiplier output, resp_id <= pending id, resp_valid <= 1, state -> DONE.
- Latency: resp_valid rises exactly SETTLE_CYCLES clocks after the accept edge.
- DONE:
  - resp_valid, resp_id and resp_product held stable until resp_ready.
  - On resp_ready: resp_valid <= 0, op_count <= op_count+1, state -> IDLE.
  - No new accept in the same cycle as resp_ready.
  - Minimum issue interval is SETTLE_CYCLES+2 clocks.
- Arithmetic: two's-complement, full 64-bit product, no truncation or saturation. 0x80000000 * 0x80000000 = 0x4000000000000000.
- Requests that are not granted must keep their valid asserted; the block does not queue them.
- busy = (state != IDLE).

Test Plan:
- Single op: reset, SETTLE_CYCLES=2, req0 a=0x00000003, b=0x00000003 -> req0_ready one cycle, resp_valid 2 clocks after accept, resp_product=9, resp_id=0, op_count=1 after resp_ready.
- Signed corners on req1: 0xFFFFFFFF*0x00000002 -> 0xFFFFFFFFFFFFFFFE; 0x80000000*0xFFFFFFFF -> 0x0000000080000000; 0x7FFFFFFF*0x7FFFFFFF -> 0x3FFFFFFF00000001; 0x80000000*0x80000000 -> 0x4000000000000000. All must carry resp_id=1.
- Contention: both valid continuously for 4 ops, resp_ready=1 -> grants in order 0,1,0,1; each ready lasts one cycle; issue interval is exactly 4 clocks.
- Backpressure: hold resp_ready=0 for 10 clocks in DONE with req0_valid=1 -> resp fields stable, req0_ready=0 throughout, busy=1; on release the next accept comes one clock later.
- Reset mid-CALC: accept 0x12345678*0x12345678, assert rst on the CALC cycle -> next cycle resp_valid=0, busy=0, op_count unchanged, and the next contention grant goes to req0.
- op_count wrap: preload by running 65536 ops (or force) -> op_count reads 0 after the 65536th response.
